glitch_scheduler: RTL

Sequencer that drives the `enable` / `enable_specific` controls of up to `NUM_CH` glitch injector instances in the fault-injection test bench. A single glitch campaign is configured through a valid/ready port, armed, and launched on a trigger edge. The campaign then emits a programmable train of glitch pulses on one selected channel: a delay, then `repeat` pulses of `width` cycles each, separated by `gap` cycles. The block sits between the test sequencer and the injector array and is the only source of injector enables.

---
 rtl/glitch_scheduler.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/glitch_scheduler.sv
// glitch_scheduler: configures, arms and launches a single glitch campaign.
// After a trigger edge it runs an optional delay and then a train of pulses
// on one injector channel. Every output is registered. Each registered
// output takes the value decoded from the next state, so it lines up with
// the state register. The only exception is cfg_error, which comes from the
// rejected transfer itself.

module glitch_scheduler #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_channel,
    input  logic                                   cfg_mode,
    input  logic [CNT_W-1:0]                       cfg_delay,
    input  logic [CNT_W-1:0]                       cfg_width,
    input  logic [CNT_W-1:0]                       cfg_gap,
    input  logic [CNT_W-1:0]                       cfg_repeat,
    input  logic                                   trigger,
    input  logic                                   abort,
    output logic [NUM_CH-1:0]                      enable,
    output logic [NUM_CH-1:0]                      enable_specific,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   cfg_error,
    output logic [CNT_W-1:0]                       glitch_count
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // One extra bit so that NUM_CH itself can be represented in the range check.
    localparam logic [CH_W:0] NUM_CH_V = (CH_W+1)'(NUM_CH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_DELAY  = 3'd2,
        S_GLITCH = 3'd3,
        S_GAP    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            state_r, state_next_s;
    logic [CNT_W-1:0]  cnt_r, cnt_next_s;
    logic [CNT_W-1:0]  glitch_count_r;
    logic              count_inc_s;
    logic              trig_prev_r;

    logic [CH_W-1:0]   cfg_channel_r;
    logic              cfg_mode_r;
    logic [CNT_W-1:0]  cfg_delay_r, cfg_width_r, cfg_gap_r, cfg_repeat_r;

    logic              cfg_ok_s, cfg_accept_s, cfg_reject_s, trig_edge_s;
    logic              cnt_last_s, last_pulse_s;
    logic [CNT_W-1:0]  width_eff_s, repeat_eff_s;

    logic [NUM_CH-1:0] onehot_s, enable_s, enable_specific_s;
    logic              busy_s, done_s, ready_s;

    logic [NUM_CH-1:0] enable_r, enable_specific_r;
    logic              busy_r, done_r, ready_r, cfg_error_r;

    assign cfg_ok_s     = ({1'b0, cfg_channel} < NUM_CH_V);
    assign cfg_accept_s = (state_r == S_IDLE) && cfg_valid && cfg_ok_s;
    assign cfg_reject_s = (state_r == S_IDLE) && cfg_valid && !cfg_ok_s;
    assign trig_edge_s  = trigger && !trig_prev_r;
    // Zero width and zero repeat both behave as one.
    assign width_eff_s  = (cfg_width_r == {CNT_W{1'b0}}) ? CNT_W'(1) : cfg_width_r;
    assign repeat_eff_s = (cfg_repeat_r == {CNT_W{1'b0}}) ? CNT_W'(1) : cfg_repeat_r;
    assign cnt_last_s   = (cnt_r == CNT_W'(1));
    // glitch_count is always below repeat_eff inside a campaign, so this sum does not wrap.
    assign last_pulse_s = ((glitch_count_r + CNT_W'(1)) == repeat_eff_s);
    assign onehot_s     = NUM_CH'(1) << cfg_channel_r;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, phase counter reload and pulse-count increment.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        count_inc_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (cfg_accept_s) state_next_s = S_ARMED;
                else              state_next_s = S_IDLE;
            end
            S_ARMED: begin
                if (abort) begin
                    state_next_s = S_IDLE;
                end else if (trig_edge_s) begin
                    if (cfg_delay_r == {CNT_W{1'b0}}) begin
                        state_next_s = S_GLITCH;
                        cnt_next_s   = width_eff_s;
                    end else begin
                        state_next_s = S_DELAY;
                        cnt_next_s   = cfg_delay_r;
                    end
                end else begin
                    state_next_s = S_ARMED;
                end
            end
            S_DELAY, S_GAP: begin
                if (abort) begin
                    state_next_s = S_IDLE;
                end else if (cnt_last_s) begin
                    state_next_s = S_GLITCH;
                    cnt_next_s   = width_eff_s;
                end else begin
                    cnt_next_s   = cnt_r - CNT_W'(1);
                end
            end
            S_GLITCH: begin
                if (abort) begin
                    state_next_s = S_IDLE;
                end else if (cnt_last_s) begin
                    count_inc_s = 1'b1;
                    if (last_pulse_s) begin
                        state_next_s = S_DONE;
                    end else if (cfg_gap_r == {CNT_W{1'b0}}) begin
                        state_next_s = S_GLITCH;
                        cnt_next_s   = width_eff_s;
                    end else begin
                        state_next_s = S_GAP;
                        cnt_next_s   = cfg_gap_r;
                    end
                end else begin
                    cnt_next_s = cnt_r - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so registered outputs align with it.
    always_comb begin
        enable_s          = {NUM_CH{1'b0}};
        enable_specific_s = {NUM_CH{1'b0}};
        busy_s            = (state_next_s != S_IDLE);
        done_s            = (state_next_s == S_DONE);
        ready_s           = (state_next_s == S_IDLE);
        if (state_next_s == S_GLITCH) begin
            if (cfg_mode_r) enable_specific_s = onehot_s;
            else            enable_s          = onehot_s;
        end else begin
            enable_s          = {NUM_CH{1'b0}};
            enable_specific_s = {NUM_CH{1'b0}};
        end
    end

    // Datapath: phase counter, pulse count, trigger history and latched config.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r          <= {CNT_W{1'b0}};
            glitch_count_r <= {CNT_W{1'b0}};
            trig_prev_r    <= 1'b0;
            cfg_channel_r  <= {CH_W{1'b0}};
            cfg_mode_r     <= 1'b0;
            cfg_delay_r    <= {CNT_W{1'b0}};
            cfg_width_r    <= {CNT_W{1'b0}};
            cfg_gap_r      <= {CNT_W{1'b0}};
            cfg_repeat_r   <= {CNT_W{1'b0}};
        end else begin
            cnt_r       <= cnt_next_s;
            trig_prev_r <= trigger;
            if (cfg_accept_s) begin
                glitch_count_r <= {CNT_W{1'b0}};
                cfg_channel_r  <= cfg_channel;
                cfg_mode_r     <= cfg_mode;
                cfg_delay_r    <= cfg_delay;
                cfg_width_r    <= cfg_width;
                cfg_gap_r      <= cfg_gap;
                cfg_repeat_r   <= cfg_repeat;
            end else if (count_inc_s) begin
                glitch_count_r <= glitch_count_r + CNT_W'(1);
            end else begin
                glitch_count_r <= glitch_count_r;
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_r          <= {NUM_CH{1'b0}};
            enable_specific_r <= {NUM_CH{1'b0}};
            busy_r            <= 1'b0;
            done_r            <= 1'b0;
            ready_r           <= 1'b1;
            cfg_error_r       <= 1'b0;
        end else begin
            enable_r          <= enable_s;
            enable_specific_r <= enable_specific_s;
            busy_r            <= busy_s;
            done_r            <= done_s;
            ready_r           <= ready_s;
            cfg_error_r       <= cfg_reject_s;
        end
    end

    assign enable          = enable_r;
    assign enable_specific = enable_specific_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign cfg_ready       = ready_r;
    assign cfg_error       = cfg_error_r;
    assign glitch_count    = glitch_count_r;

endmodule
